// File: rtl/call_stack_ctrl_if.sv
// Bundle of the call-stack controller request/response signals.
// The fetch/decode side drives requests as master; the controller is the slave.
interface call_stack_ctrl_if #(
  parameter int PC_WIDTH = 5
);
  logic                cs_call;
  logic                cs_ret;
  logic [PC_WIDTH-1:0] cs_call_target;
  logic [PC_WIDTH-1:0] cs_ret_addr_in;
  logic                cs_busy;
  logic                cs_pc_load;
  logic [PC_WIDTH-1:0] cs_pc_value;
  logic                rf_stack_push;
  logic                rf_stack_pop;
  logic [PC_WIDTH-1:0] rf_stack_pointer;
  logic                cs_overflow;
  logic                cs_underflow;

  modport master (
    output cs_call, cs_ret, cs_call_target, cs_ret_addr_in,
    input  cs_busy, cs_pc_load, cs_pc_value, rf_stack_push, rf_stack_pop,
           rf_stack_pointer, cs_overflow, cs_underflow
  );

  modport slave (
    input  cs_call, cs_ret, cs_call_target, cs_ret_addr_in,
    output cs_busy, cs_pc_load, cs_pc_value, rf_stack_push, rf_stack_pop,
           rf_stack_pointer, cs_overflow, cs_underflow
  );
endinterface

// File: rtl/call_stack_ctrl.sv
// Call/return controller: keeps a small return-address stack, sequences the
// register-file window push/pop strobes and the PC load strobe for CALL/RET.
module call_stack_ctrl #(
  parameter int PC_WIDTH = 5,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  call_stack_ctrl_if.slave    bus
);

  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_WIDTH-1:0] SP_FULL = PC_WIDTH'(DEPTH);
  localparam logic [PC_WIDTH-1:0] SP_ONE  = PC_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    CALL_PUSH,
    CALL_JUMP,
    RET_POP
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PC_WIDTH-1:0] sp;
  logic [PC_WIDTH-1:0] target_q;
  logic [PC_WIDTH-1:0] ret_addr_q;
  logic                overflow_q;
  logic                underflow_q;
  logic [PC_WIDTH-1:0] pop_addr;

  // Slot s (1..DEPTH) lives at entry s-1; never reset, contents only matter once pushed.
  logic [PC_WIDTH-1:0] ret_mem [0:DEPTH-1];

  // State register; reset drops any operation in flight straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: requests are only looked at in IDLE, CALL wins over RET.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.cs_call) begin
          if (sp < SP_FULL) state_next = CALL_PUSH;
        end else if (bus.cs_ret) begin
          if (sp != '0) state_next = RET_POP;
        end
      end
      CALL_PUSH: state_next = CALL_JUMP;
      CALL_JUMP: state_next = IDLE;
      RET_POP:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Stack pointer, CALL latches and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp          <= '0;
      target_q    <= '0;
      ret_addr_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cs_call) begin
            if (sp < SP_FULL) begin
              target_q   <= bus.cs_call_target;
              ret_addr_q <= bus.cs_ret_addr_in;
              sp         <= sp + SP_ONE;
            end else begin
              overflow_q <= 1'b1;
            end
          end else if (bus.cs_ret) begin
            if (sp == '0) underflow_q <= 1'b1;
          end
        end
        RET_POP: sp <= sp - SP_ONE;
        default: ;
      endcase
    end
  end

  // Return-address write happens in CALL_PUSH, when sp already names the new slot.
  always_ff @(posedge clk) begin
    if (state == CALL_PUSH) begin
      ret_mem[IDX_W'(sp - SP_ONE)] <= ret_addr_q;
    end
  end

  assign pop_addr = ret_mem[IDX_W'(sp - SP_ONE)];

  // Strobes and PC value decoded purely from state so reset clears them at once.
  always_comb begin
    bus.cs_pc_value = '0;
    case (state)
      CALL_JUMP: bus.cs_pc_value = target_q;
      RET_POP:   bus.cs_pc_value = pop_addr;
      default:   bus.cs_pc_value = '0;
    endcase
  end

  assign bus.cs_busy          = (state != IDLE);
  assign bus.rf_stack_push    = (state == CALL_PUSH);
  assign bus.rf_stack_pop     = (state == RET_POP);
  assign bus.cs_pc_load       = (state == CALL_JUMP) || (state == RET_POP);
  assign bus.rf_stack_pointer = sp;
  assign bus.cs_overflow      = overflow_q;
  assign bus.cs_underflow     = underflow_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed table, corner sequences,
// then random traffic compared against a stack/timeline reference model.
module tb_call_stack_ctrl;

  localparam int PC_WIDTH = 5;
  localparam int DEPTH    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  call_stack_ctrl_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  call_stack_ctrl #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       busy;
    logic       push;
    logic       pop;
    logic       load;
    logic [4:0] value;
    logic [4:0] ptr;
    logic       ovf;
    logic       unf;
  } obs_t;

  typedef struct {
    logic       call;
    logic       ret;
    logic [4:0] tgt;
    logic [4:0] ra;
    obs_t       exp;
  } vec_t;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: the stack as a queue, plus a timeline of per-cycle
  // expectations scheduled when an operation is accepted.
  logic [4:0] stk [$];
  obs_t       sched [$];
  obs_t       cur;
  logic       m_ovf;
  logic       m_unf;

  function automatic obs_t mk(logic busy, logic push, logic pop, logic load,
                              logic [4:0] value, logic [4:0] ptr,
                              logic ovf, logic unf);
    obs_t o;
    o.busy = busy; o.push = push; o.pop = pop; o.load = load;
    o.value = value; o.ptr = ptr; o.ovf = ovf; o.unf = unf;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("busy=%0b push=%0b pop=%0b load=%0b value=%h ptr=%0d ovf=%0b unf=%0b",
                     o.busy, o.push, o.pop, o.load, o.value, o.ptr, o.ovf, o.unf);
  endfunction

  task automatic model_reset();
    stk.delete();
    sched.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    cur   = mk(0, 0, 0, 0, 5'h0, 5'd0, 0, 0);
  endtask

  task automatic model_edge(input logic call, input logic ret,
                            input logic [4:0] tgt, input logic [4:0] ra);
    obs_t r;
    if (!cur.busy) begin
      if (call) begin
        if (stk.size() < DEPTH) begin
          stk.push_back(ra);
          sched.push_back(mk(1, 1, 0, 0, 5'h0, 5'(stk.size()), 0, 0));
          sched.push_back(mk(1, 0, 0, 1, tgt, 5'(stk.size()), 0, 0));
        end else begin
          m_ovf = 1'b1;
        end
      end else if (ret) begin
        if (stk.size() > 0) begin
          r = mk(1, 0, 1, 1, stk[$], 5'(stk.size()), 0, 0);
          sched.push_back(r);
          void'(stk.pop_back());
        end else begin
          m_unf = 1'b1;
        end
      end
    end
    if (sched.size() > 0) cur = sched.pop_front();
    else                  cur = mk(0, 0, 0, 0, 5'h0, 5'(stk.size()), 0, 0);
    cur.ovf = m_ovf;
    cur.unf = m_unf;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.busy  = bus.cs_busy;
    o.push  = bus.rf_stack_push;
    o.pop   = bus.rf_stack_pop;
    o.load  = bus.cs_pc_load;
    o.value = bus.cs_pc_value;
    o.ptr   = bus.rf_stack_pointer;
    o.ovf   = bus.cs_overflow;
    o.unf   = bus.cs_underflow;
    return o;
  endfunction

  task automatic check_output(input string name, input obs_t exp);
    obs_t got;
    logic bad;
    got = sample();
    bad = (got.busy !== exp.busy) || (got.push !== exp.push) ||
          (got.pop !== exp.pop) || (got.load !== exp.load) ||
          (got.ptr !== exp.ptr) || (got.ovf !== exp.ovf) ||
          (got.unf !== exp.unf) || (exp.load && (got.value !== exp.value));
    n_checks++;
    if (bad) begin
      n_fails++;
      $display("[TB] FAIL %s at %0t: got {%s} required {%s}", name, $time, fmt(got), fmt(exp));
    end
  endtask

  // Drive one cycle of requests, clock it, advance the model and compare.
  task automatic apply_stimulus(input logic call, input logic ret,
                                input logic [4:0] tgt, input logic [4:0] ra);
    bus.cs_call        = call;
    bus.cs_ret         = ret;
    bus.cs_call_target = tgt;
    bus.cs_ret_addr_in = ra;
    @(posedge clk);
    model_edge(call, ret, tgt, ra);
    @(negedge clk);
    check_output("model", cur);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.cs_call = 1'b0; bus.cs_ret = 1'b0;
    bus.cs_call_target = '0; bus.cs_ret_addr_in = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("reset", mk(0, 0, 0, 0, 5'h0, 5'd0, 0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [17];

  initial begin
    logic       rc, rr;
    logic [4:0] rt, ra;
    int         r;

    bus.cs_call = 1'b0; bus.cs_ret = 1'b0;
    bus.cs_call_target = '0; bus.cs_ret_addr_in = '0;
    model_reset();

    // call ret  tgt    ra    busy push pop load value ptr ovf unf
    tbl[0]  = '{0, 1, 5'h00, 5'h00, mk(0, 0, 0, 0, 5'h00, 5'd0, 0, 1)};
    tbl[1]  = '{1, 0, 5'h10, 5'h03, mk(1, 1, 0, 0, 5'h00, 5'd1, 0, 1)};
    tbl[2]  = '{0, 0, 5'h00, 5'h00, mk(1, 0, 0, 1, 5'h10, 5'd1, 0, 1)};
    tbl[3]  = '{0, 0, 5'h00, 5'h00, mk(0, 0, 0, 0, 5'h00, 5'd1, 0, 1)};
    tbl[4]  = '{0, 1, 5'h00, 5'h00, mk(1, 0, 1, 1, 5'h03, 5'd1, 0, 1)};
    tbl[5]  = '{0, 0, 5'h00, 5'h00, mk(0, 0, 0, 0, 5'h00, 5'd0, 0, 1)};
    tbl[6]  = '{1, 0, 5'h01, 5'h0A, mk(1, 1, 0, 0, 5'h00, 5'd1, 0, 1)};
    tbl[7]  = '{1, 0, 5'h1E, 5'h1E, mk(1, 0, 0, 1, 5'h01, 5'd1, 0, 1)};
    tbl[8]  = '{0, 0, 5'h00, 5'h00, mk(0, 0, 0, 0, 5'h00, 5'd1, 0, 1)};
    tbl[9]  = '{1, 0, 5'h02, 5'h0B, mk(1, 1, 0, 0, 5'h00, 5'd2, 0, 1)};
    tbl[10] = '{0, 0, 5'h00, 5'h00, mk(1, 0, 0, 1, 5'h02, 5'd2, 0, 1)};
    tbl[11] = '{0, 0, 5'h00, 5'h00, mk(0, 0, 0, 0, 5'h00, 5'd2, 0, 1)};
    tbl[12] = '{1, 1, 5'h03, 5'h0C, mk(1, 1, 0, 0, 5'h00, 5'd3, 0, 1)};
    tbl[13] = '{1, 0, 5'h1F, 5'h1F, mk(1, 0, 0, 1, 5'h03, 5'd3, 0, 1)};
    tbl[14] = '{0, 0, 5'h00, 5'h00, mk(0, 0, 0, 0, 5'h00, 5'd3, 0, 1)};
    tbl[15] = '{0, 1, 5'h00, 5'h00, mk(1, 0, 1, 1, 5'h0C, 5'd3, 0, 1)};
    tbl[16] = '{0, 0, 5'h00, 5'h00, mk(0, 0, 0, 0, 5'h00, 5'd2, 0, 1)};

    $display("[TB] directed table");
    do_reset();
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(tbl[i].call, tbl[i].ret, tbl[i].tgt, tbl[i].ra);
      check_output($sformatf("vec%0d", i), tbl[i].exp);
    end

    $display("[TB] nested calls, overflow, unwind, underflow");
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      apply_stimulus(1, 0, 5'(i + 16), 5'(i));
      apply_stimulus(0, 0, 5'h0, 5'h0);
      apply_stimulus(0, 0, 5'h0, 5'h0);
    end
    apply_stimulus(1, 0, 5'h1F, 5'h1F);
    check_output("overflow", mk(0, 0, 0, 0, 5'h00, 5'd8, 1, 0));
    apply_stimulus(0, 0, 5'h0, 5'h0);
    check_output("overflow_hold", mk(0, 0, 0, 0, 5'h00, 5'd8, 1, 0));
    for (int i = DEPTH; i >= 1; i--) begin
      apply_stimulus(0, 1, 5'h0, 5'h0);
      check_output($sformatf("unwind%0d", i), mk(1, 0, 1, 1, 5'(i), 5'(i), 1, 0));
      apply_stimulus(0, 0, 5'h0, 5'h0);
    end
    apply_stimulus(0, 1, 5'h0, 5'h0);
    check_output("underflow", mk(0, 0, 0, 0, 5'h00, 5'd0, 1, 1));
    apply_stimulus(0, 0, 5'h0, 5'h0);
    check_output("flags_sticky", mk(0, 0, 0, 0, 5'h00, 5'd0, 1, 1));

    $display("[TB] reset during CALL_PUSH");
    do_reset();
    apply_stimulus(1, 0, 5'h10, 5'h03);
    check_output("pre_abort_push", mk(1, 1, 0, 0, 5'h00, 5'd1, 0, 0));
    bus.cs_call = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("abort_immediate", mk(0, 0, 0, 0, 5'h00, 5'd0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    check_output("abort_no_load", mk(0, 0, 0, 0, 5'h00, 5'd0, 0, 0));
    rst_n = 1'b1;
    apply_stimulus(0, 0, 5'h0, 5'h0);
    check_output("abort_released", mk(0, 0, 0, 0, 5'h00, 5'd0, 0, 0));

    $display("[TB] random traffic");
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 299));
      if (r == 0) begin
        do_reset();
      end else begin
        r  = r % 100;
        rc = (r < 40);
        rr = (r >= 30) && (r < 75);
        rt = 5'($urandom);
        ra = 5'($urandom);
        apply_stimulus(rc, rr, rt, ra);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/call_stack_ctrl.md
CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 Parameter PC_WIDTH, default 5, program-counter and stack-pointer width.
REQ-002 Parameter DEPTH, default 8, number of call-stack slots (1..DEPTH); DEPTH SHALL be <= 2**PC_WIDTH-1.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cs_call  input  1  CALL request, sampled only in IDLE.
REQ-006 cs_ret  input  1  RET request, sampled only in IDLE.
REQ-007 cs_call_target  input  PC_WIDTH  CALL destination address.
REQ-008 cs_ret_addr_in  input  PC_WIDTH  return address (PC of next instruction) from fetch.
REQ-009 cs_busy  output  1  high whenever state is not IDLE.
REQ-010 cs_pc_load  output  1  one-cycle strobe: PC SHALL load cs_pc_value.
REQ-011 cs_pc_value  output  PC_WIDTH  jump target or return address.
REQ-012 rf_stack_push  output  1  register-file window save/clear strobe.
REQ-013 rf_stack_pop  output  1  register-file window restore strobe.
REQ-014 rf_stack_pointer  output  PC_WIDTH  current stack depth / active slot, 0 = empty.
REQ-015 cs_overflow  output  1  sticky: CALL attempted with stack full.
REQ-016 cs_underflow  output  1  sticky: RET attempted with stack empty.

Function
REQ-017 FSM states SHALL be IDLE, CALL_PUSH, CALL_JUMP, RET_POP.
REQ-018 Internal return-address memory SHALL hold DEPTH entries of PC_WIDTH bits, indexed by slot 1..DEPTH.
REQ-019 IDLE, cs_call=1, sp<DEPTH: latch target and return address, sp<=sp+1, go CALL_PUSH.
REQ-020 CALL_PUSH: rf_stack_push=1, rf_stack_pointer=new sp, ret_mem[sp]<=latched return address; go CALL_JUMP.
REQ-021 CALL_JUMP: cs_pc_load=1, cs_pc_value=latched target; go IDLE.
REQ-022 CALL latency: accept edge at cycle 0, push strobe in cycle 1, pc_load strobe in cycle 2, IDLE in cycle 3.
REQ-023 IDLE, cs_ret=1, cs_call=0, sp>0: go RET_POP.
REQ-024 RET_POP: rf_stack_pop=1 and cs_pc_load=1 together, rf_stack_pointer=sp (>0), cs_pc_value=ret_mem[sp]; sp<=sp-1 at end of cycle; go IDLE.
REQ-025 rf_stack_pointer SHALL be registered sp, stable throughout every push/pop strobe cycle.
REQ-026 cs_call and cs_ret both high in IDLE: CALL SHALL be processed, RET dropped, no flag set.
REQ-027 Requests while cs_busy=1 SHALL be ignored, not queued.
REQ-028 cs_call with sp==DEPTH: cs_overflow<=1, no push, no pc_load, sp unchanged, stay IDLE.
REQ-029 cs_ret with sp==0: cs_underflow<=1, no pop, no pc_load, stay IDLE.
REQ-030 rf_stack_push, rf_stack_pop, cs_pc_load SHALL each be high for exactly one cycle per operation and never simultaneously push with pop.
REQ-031 sp SHALL never wrap: range 0..DEPTH inclusive.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, sp=0, all outputs 0, both sticky flags 0, latches 0.
REQ-033 Reset mid-CALL/RET SHALL abort the operation with no further strobes; ret_mem contents need not be cleared.
REQ-034 Sticky flags SHALL clear only by reset.

Verification
REQ-035 Reset, then CALL target=5'h10 ret=5'h03 -> cycle1 push, pointer=1; cycle2 pc_load, value=5'h10; sp=1.
REQ-036 Following RET -> next cycle pop=1, pc_load=1, pointer=1, value=5'h03; then sp=0.
REQ-037 Nested 8 CALLs (ret 1..8), 9th CALL -> cs_overflow=1, no strobes, sp=8; 8 RETs return 8,7,..,1 in order.
REQ-038 RET at sp=0 -> cs_underflow=1, no pop, no pc_load, sp=0.
REQ-039 cs_call=cs_ret=1 at sp=2 -> CALL executed, sp=3, no pop; cs_call pulsed in CALL_PUSH ignored.
REQ-040 rst_n low during CALL_PUSH -> outputs 0 immediately, no pc_load, sp=0 after release.
